// File: rtl/block_ram_word_writer.sv
// Stream-to-RAM loader: one DATA_WIDTH word per beat, lane-by-lane then address-by-address.
// Write port outputs are registered (latency 1); in_ready is high only in WRITE, so the stream stalls outside a job.
module block_ram_word_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int NUM_WORDS  = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           num_addrs,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [AW-1:0]         wr_addr,
  output logic [NUM_WORDS-1:0]  wr_en,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [LW-1:0]        LAST_LANE = LW'(NUM_WORDS - 1);
  localparam logic [LW-1:0]        LANE_ONE  = LW'(1);
  localparam logic [AW-1:0]        ADDR_ONE  = AW'(1);
  localparam logic [AW:0]          REM_ONE   = (AW+1)'(1);
  localparam logic [AW:0]          REM_ZERO  = '0;
  localparam logic [NUM_WORDS-1:0] LANE0_EN  = NUM_WORDS'(1);

  state_t          state, state_nxt;
  logic [AW-1:0]   addr;
  logic [AW:0]     remaining;
  logic [LW-1:0]   lane;
  logic            beat;
  logic            last_lane;

  assign in_ready  = (state == WRITE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign beat      = in_valid & in_ready;
  assign last_lane = (lane == LAST_LANE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (num_addrs == REM_ZERO) ? DONE : WRITE;
      WRITE: if (beat && last_lane && remaining == REM_ONE) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // wr_en defaults to zero every cycle so a stall or job end never repeats a write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      lane      <= '0;
      wr_data   <= '0;
      wr_addr   <= '0;
      wr_en     <= '0;
    end else begin
      wr_en <= '0;
      if (state == IDLE && start) begin
        addr      <= base_addr;
        remaining <= num_addrs;
        lane      <= '0;
      end else if (beat) begin
        wr_data <= in_data;
        wr_addr <= addr;
        wr_en   <= LANE0_EN << lane;
        if (last_lane) begin
          lane      <= '0;
          addr      <= addr + ADDR_ONE;
          remaining <= remaining - REM_ONE;
        end else begin
          lane <= lane + LANE_ONE;
        end
      end
    end
  end

endmodule
